seg7_scan: RTL
==============

# seg7_scan

Eight-digit multiplexed seven-segment display driver that sits directly downstream of the CPU core in `top`. It takes the 32-bit value the CPU presents for display, eight decimal-point bits and control flags. It time-multiplexes these onto one shared active-low segment bus plus eight active-low digit strobes. The segment and strobe outputs drive the board pins `a`..`g`, `dp` and `d0`..`d7` directly.

## Interface
- `DIV`, default 25000: clocks per digit slot, 0.5 ms at 50 MHz (4 ms frame). Legal range 2..2^20.
- `clk`  in  1  system clock (50 MHz on board, 20 ns period in simulation).
- `rst_n`  in  1  reset: one clock, asynchronous assert, active-low.
- `value`  in  32  eight hex nibbles; nibble k (`value[4k+3:4k]`) is shown on digit k.
- `dp_mask`  in  8  bit k = 1 lights the decimal point on digit k.
- `blank_lz`  in  1  1 = blank leading zero digits.
- `enable`  in  1  0 = all digit strobes off; scanning continues.
- `seg_n`  out  7  {g,f,e,d,c,b,a}, active-low.
- `dp_n`  out  1  decimal point, active-low.
- `an_n`  out  8  digit strobes {d7..d0}, active-low, at most one low.
- `frame_tick`  out  1  one-cycle pulse at each frame start.

## Operation
- **Slot counter.** `cnt` counts 0..DIV-1. When `cnt`==DIV-1 it wraps to 0 and digit index `idx` (3 bits) increments, wrapping 7->0.
- **Input snapshot.** On every edge where `cnt`==0 and `idx`==0 (frame start), `value`, `dp_mask` and `blank_lz` are copied into shadow registers.
  - All displayed data comes only from the shadow registers, so there is no tearing within a frame.
  - Input changes take effect at the next frame start.
- **Hex decode (active-low gfedcba).**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Blank=1111111.
- **Leading-zero blanking.** Digit k (1..7) is blanked when shadow `blank_lz`=1 and shadow nibbles k..7 are all zero. Digit 0 is never blanked.
- **Decimal point.** `dp_n` = ~shadow `dp_mask[idx]`, independent of blanking.
- **Digit strobe.** `an_n` = ~(1<<idx) when `enable`=1, else 8'hFF. `enable` is sampled every cycle, not snapshotted.
- **Registered outputs.** `seg_n`, `dp_n`, `an_n` and `frame_tick` are all registers, so no combinational glitches reach the pins.

## Timing
- **Reset values** (asserted async; held while `rst_n`=0):
  - `cnt`=0, `idx`=0, shadow registers=0.
  - `seg_n`=7'h7F, `dp_n`=1, `an_n`=8'hFF, `frame_tick`=0.
- **First frame.** The first rising edge after `rst_n` goes high has `cnt`==0 and `idx`==0, so it performs the first snapshot.
- **Output latency.** Outputs update exactly one clock after the slot starts.
  - Slot k starts on the edge where `cnt` becomes 0 with `idx`=k.
  - The outputs show digit k from the following edge until one clock after slot k+1 starts.
  - The snapshot and the digit-0 decode are pipelined so that digit 0 of a frame already uses the new snapshot.
- **frame_tick.** High for exactly one clock, coinciding with the first cycle digit 0 is driven. Period = 8*DIV clocks.
- **Slot length.** Every strobe is low for exactly DIV consecutive clocks. `idx` 7->0 wrap is seamless.
- **enable.** An `enable` change reaches `an_n` one clock later. Toggling `enable` does not disturb `cnt`, `idx`, shadow registers or `frame_tick`.
- **Reset mid-slot.** All state and outputs return to reset values immediately (async). There is no partial-frame output after release.
- **Input change on a snapshot edge.** The value present at that edge is captured.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles with `value`=32'h12345678 -> `an_n`=FF, `seg_n`=7F, `dp_n`=1, `frame_tick`=0 throughout.
- **Scan order and decode** (DIV=4, `value`=32'h89ABCDEF, `dp_mask`=0, `enable`=1, `blank_lz`=0) -> per slot:
  - `an_n` sequence FE,FD,FB,F7,EF,DF,BF,7F, each 4 clocks.
  - `seg_n` sequence F=0001110, E=0000110, d=0100001, C=1000110, b=0000011, A=0001000, 9=0010000, 8=0000000.
  - `frame_tick` every 32 clocks.
- **Leading-zero blanking** (`value`=32'h00000409, `blank_lz`=1) -> digits 0..2 show 9, 0, 4; digits 3..7 show `seg_n`=1111111. With `value`=0, digit 0 shows 1000000 and digits 1..7 are blank.
- **Snapshot / no tearing.** Change `value` 32'h11111111 -> 32'h22222222 while digit 3 is shown -> digits 4..7 of that frame still show 1111001; next frame all show 0100100.
- **Decimal point and enable** (`dp_mask`=8'h81) -> `dp_n`=0 only during digits 0 and 7. Then drop `enable` for 10 cycles -> `an_n`=FF one clock later, and `frame_tick` period stays 32.
- **Async reset mid-frame.** Pulse `rst_n` low for 5 ns at digit 5 -> outputs blank immediately. After release the first `frame_tick` comes one clock after the first edge, with `an_n`=FE.

Source files
------------

// File: rtl/seg7_scan.sv
// seg7_scan: eight-digit multiplexed seven-segment driver.
// Scans eight hex nibbles onto one shared active-low segment bus with
// active-low digit strobes. Inputs are snapshotted once per frame so a
// frame never mixes old and new data. Every pin-facing output is a
// register, so no combinational glitches reach the board.
//
// Slot timing: cnt runs 0..DIV-1 inside each digit slot and idx selects
// the digit. After any clock edge, the outputs show the digit that idx
// held before that edge. Each strobe is therefore low for exactly DIV
// clocks, lagging the slot counter by one clock.
//
// On the frame-start edge (cnt==0, idx==0), the shadow registers load
// from the live inputs. On that same edge, digit 0 is decoded straight
// from those live inputs, so digit 0 already reflects the new snapshot.
module seg7_scan #(
  parameter int DIV = 25000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  input  logic        enable,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n,
  output logic        frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  // slot counter and digit index
  logic [CW-1:0] cnt;
  logic [2:0]    idx;

  // per-frame shadow copies of the display inputs
  logic [31:0]   sh_value;
  logic [7:0]    sh_dp;
  logic          sh_blz;

  // decode path signals
  logic          frame_start;
  logic          slot_end;
  logic [31:0]   src_value;
  logic [7:0]    src_dp;
  logic          src_blz;
  logic [31:0]   upper;
  logic [3:0]    nib;
  logic          blank_digit;
  logic [6:0]    seg_next;

  assign frame_start = (cnt == '0) && (idx == 3'd0);
  assign slot_end    = (cnt == CNT_LAST);

  // Hex to active-low {g,f,e,d,c,b,a} segment pattern
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Pick the data source and decode the current digit with blanking
  always_comb begin
    src_value   = frame_start ? value    : sh_value;
    src_dp      = frame_start ? dp_mask  : sh_dp;
    src_blz     = frame_start ? blank_lz : sh_blz;
    // Nibbles idx..7 shifted down; all-zero means this digit is a leading zero.
    upper       = src_value >> {idx, 2'b00};
    nib         = upper[3:0];
    blank_digit = src_blz && (idx != 3'd0) && (upper == 32'd0);
    seg_next    = blank_digit ? 7'h7F : hex7(nib);
  end

  // Advance the slot counter and digit index; idx wraps 7->0 seamlessly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Capture the display inputs once per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_value <= 32'd0;
      sh_dp    <= 8'd0;
      sh_blz   <= 1'b0;
    end else if (frame_start) begin
      sh_value <= value;
      sh_dp    <= dp_mask;
      sh_blz   <= blank_lz;
    end
  end

  // Register every pin output; enable gates only the strobes, each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      an_n       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      seg_n      <= seg_next;
      dp_n       <= ~src_dp[idx];
      an_n       <= enable ? ~(8'd1 << idx) : 8'hFF;
      frame_tick <= frame_start;
    end
  end

endmodule
